// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictors: saturating counter step,
// weakly-not-taken reset value and the gshare index hash.
package bp_pkg;

  function automatic logic [31:0] sat_next(input logic [31:0] ctr,
                                           input logic        taken,
                                           input int unsigned ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (taken) begin
      sat_next = (ctr == max_v) ? ctr : ctr + 32'd1;
    end else begin
      sat_next = (ctr == 32'd0) ? ctr : ctr - 32'd1;
    end
  endfunction

  // Largest value whose MSB is still clear; a 1-bit counter gives 0.
  function automatic logic [31:0] weak_nt(input int unsigned ctr_w);
    weak_nt = (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [31:0] hash_index(input logic [31:0] pc_bits,
                                             input logic [31:0] ghr);
    hash_index = pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: flop array of saturating counters with one
// write-first read port and one read-modify-write update port.
module gshare_pht
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [CTR_W-1:0]   rd_ctr,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_taken
);

  localparam int unsigned DEPTH = 32'd1 << INDEX_W;
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(weak_nt(CTR_W));

  logic [CTR_W-1:0] pht_r [DEPTH];
  logic [CTR_W-1:0] wr_next_s;

  // Next value of the entry being updated.
  always_comb begin
    wr_next_s = CTR_W'(sat_next(32'(pht_r[wr_index]), wr_taken, CTR_W));
  end

  // Read port; a same-cycle update to the same entry is forwarded.
  always_comb begin
    if (wr_en && (wr_index == rd_index)) begin
      rd_ctr = wr_next_s;
    end else begin
      rd_ctr = pht_r[rd_index];
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pht_r[i] <= INIT_CTR;
      end
    end else if (wr_en) begin
      pht_r[wr_index] <= wr_next_s;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor global history indexes the PHT,
// registered prediction, non-speculative history and mispredict count.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 6,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [PC_W-1:0]    req_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  input  logic               upd_pred,
  output logic [CNT_W-1:0]   mispredict_cnt
);

  logic [INDEX_W-1:0] ghr_ext_s;
  logic [INDEX_W-1:0] idx_s;
  logic [CTR_W-1:0]   rd_ctr_s;
  logic               pred_valid_r;
  logic               pred_taken_r;
  logic [INDEX_W-1:0] pred_index_r;
  logic [CNT_W-1:0]   mispredict_cnt_r;
  logic               unused_pc_s;

  // Only req_pc[INDEX_W+1:2] feeds the hash.
  assign unused_pc_s = ^req_pc;

  generate
    if (HIST_W == 0) begin : g_bimodal
      assign ghr_ext_s = {INDEX_W{1'b0}};
    end else begin : g_hist
      logic [HIST_W-1:0] ghr_r;

      // Global history, shifted only by resolved branches.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_r <= {HIST_W{1'b0}};
        end else if (upd_valid) begin
          ghr_r <= HIST_W'({ghr_r, upd_taken});
        end
      end

      assign ghr_ext_s = INDEX_W'(ghr_r);
    end
  endgenerate

  assign idx_s = INDEX_W'(hash_index(32'(req_pc[INDEX_W+1:2]), 32'(ghr_ext_s)));

  gshare_pht #(
    .INDEX_W (INDEX_W),
    .CTR_W   (CTR_W)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (idx_s),
    .rd_ctr   (rd_ctr_s),
    .wr_en    (upd_valid),
    .wr_index (upd_index),
    .wr_taken (upd_taken)
  );

  // Prediction output registers; direction and index hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_index_r <= {INDEX_W{1'b0}};
    end else begin
      pred_valid_r <= req_valid;
      if (req_valid) begin
        pred_taken_r <= rd_ctr_s[CTR_W-1];
        pred_index_r <= idx_s;
      end
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt_r <= {CNT_W{1'b0}};
    end else if (upd_valid && (upd_taken != upd_pred) &&
                 (mispredict_cnt_r != {CNT_W{1'b1}})) begin
      mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign pred_valid     = pred_valid_r;
  assign pred_taken     = pred_taken_r;
  assign pred_index     = pred_index_r;
  assign mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with a reference model and a
// prediction scoreboard.
module tb_gshare_predictor;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned HIST_W  = 6;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic [PC_W-1:0]    req_pc;
  logic               pred_valid;
  logic               pred_taken;
  logic [INDEX_W-1:0] pred_index;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic               upd_taken;
  logic               upd_pred;
  logic [CNT_W-1:0]   mispredict_cnt;

  typedef struct packed {
    logic       taken;
    logic [5:0] idx;
  } pred_t;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] m_pht [64];
  logic [5:0] m_ghr;
  logic [3:0] m_cnt;
  logic       m_last_taken;
  logic [5:0] m_last_idx;
  pred_t      sb_q [$];

  gshare_predictor #(
    .INDEX_W (INDEX_W),
    .CTR_W   (CTR_W),
    .HIST_W  (HIST_W),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_index     (pred_index),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .upd_pred       (upd_pred),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    else   return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] pc_for(input logic [5:0] target);
    return {24'd0, target ^ m_ghr, 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 2'd1;
    m_ghr        = 6'd0;
    m_cnt        = 4'd0;
    m_last_taken = 1'b0;
    m_last_idx   = 6'd0;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_pc    = 32'd0;
    upd_valid = 1'b0;
    upd_index = 6'd0;
    upd_taken = 1'b0;
    upd_pred  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, predict with the model, check after posedge.
  task automatic step(input logic req, input logic [31:0] pc, input logic upd,
                      input logic [5:0] uidx, input logic ut, input logic up);
    logic [5:0] idx;
    logic [1:0] c;
    pred_t      e;
    @(negedge clk);
    req_valid = req;
    req_pc    = pc;
    upd_valid = upd;
    upd_index = uidx;
    upd_taken = ut;
    upd_pred  = up;
    idx = pc[7:2] ^ m_ghr;
    c   = m_pht[idx];
    if (upd && uidx == idx) c = m_sat(c, ut);
    if (req) sb_q.push_back({c[1], idx});
    if (upd) begin
      m_pht[uidx] = m_sat(m_pht[uidx], ut);
      m_ghr       = {m_ghr[4:0], ut};
      if (ut != up && m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
    end
    @(posedge clk);
    #1;
    check("pred_valid", 32'(pred_valid), 32'(req));
    if (req && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      m_last_taken = e.taken;
      m_last_idx   = e.idx;
    end
    check("pred_taken", 32'(pred_taken), 32'(m_last_taken));
    check("pred_index", 32'(pred_index), 32'(m_last_idx));
    check("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] rpc;
    logic [5:0]  ui;

    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_index", 32'(pred_index), 32'd0);
    check("rst_mispredict", 32'(mispredict_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First lookup after reset.
    step(1'b1, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    check("first_idx", 32'(pred_index), 32'h10);
    check("first_taken", 32'(pred_taken), 32'd0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);

    // History hash.
    apply_reset();
    step(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    check("hist_idx", 32'(pred_index), 32'h13);

    // Write-first bypass.
    apply_reset();
    step(1'b1, 32'hc, 1'b1, 6'd3, 1'b1, 1'b0);
    check("bypass_idx", 32'(pred_index), 32'd3);
    check("bypass_taken", 32'(pred_taken), 32'd1);

    // Saturation at both ends of the counter.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b1);
    step(1'b1, pc_for(6'd5), 1'b0, 6'd0, 1'b0, 1'b0);
    check("sat_hi_idx", 32'(pred_index), 32'd5);
    check("sat_hi_taken", 32'(pred_taken), 32'd1);
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b0, 1'b0);
    step(1'b1, pc_for(6'd5), 1'b0, 6'd0, 1'b0, 1'b0);
    check("sat_hi_minus1", 32'(pred_taken), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 6'd5, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1, 1'b1);
    step(1'b1, pc_for(6'd5), 1'b0, 6'd0, 1'b0, 1'b0);
    check("sat_lo_taken", 32'(pred_taken), 32'd0);

    // Mispredict counter saturation.
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 6'(i), i[0], ~i[0]);
    check("miss_sat", 32'(mispredict_cnt), 32'd15);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 6'(i), i[0], i[0]);
    check("miss_hold", 32'(mispredict_cnt), 32'd15);

    // Mixed traffic, a third of updates aimed at the looked-up entry.
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      rpc = $urandom;
      ui  = (k % 3 == 0) ? (rpc[7:2] ^ m_ghr) : 6'($urandom);
      step(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)), ui,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while a prediction is valid.
    apply_reset();
    step(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 6'h10, 1'b1, 1'b0);
    step(1'b1, 32'h84, 1'b0, 6'd0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(pred_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_valid", 32'(pred_valid), 32'd0);
    check("async_cnt", 32'(mispredict_cnt), 32'd0);
    check("async_idx", 32'(pred_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    check("post_rst_idx", 32'(pred_index), 32'h10);
    check("post_rst_taken", 32'(pred_taken), 32'd0);

    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare branch direction predictor replacing the single 2-bit saturating counter. Holds a pattern history table (PHT) of 2^INDEX_W saturating counters indexed by PC XOR global history, with a registered prediction port and a separate resolution/update port. It sits between fetch, which issues lookups, and branch resolution, which returns outcomes, and keeps a saturating misprediction count for performance monitoring.

## Interface
- INDEX_W, 6: PHT index width; table depth 2^INDEX_W.
- CTR_W, 2: counter width, ≥1; MSB=1 means predict taken.
- HIST_W, 6: global history register (GHR) width, 0 ≤ HIST_W ≤ INDEX_W.
- PC_W, 32: PC width, ≥ INDEX_W+2.
- CNT_W, 16: misprediction counter width.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request this cycle.
- req_pc  in  PC_W  branch PC; bits [1:0] ignored.
- pred_valid  out  1  registered; high one cycle after an accepted request.
- pred_taken  out  1  predicted direction.
- pred_index  out  INDEX_W  PHT index used; fetch carries it to resolution.
- upd_valid  in  1  resolved branch this cycle.
- upd_index  in  INDEX_W  index returned from pred_index.
- upd_taken  in  1  actual direction.
- upd_pred  in  1  direction originally predicted.
- mispredict_cnt  out  CNT_W  saturating count of upd_valid with upd_taken≠upd_pred.

## Operation
- Reset (async, immediate): all PHT entries = WEAK_NT = 2^(CTR_W-1)-1 (CTR_W=1 → 0); GHR = 0; pred_valid, pred_taken, pred_index = 0; mispredict_cnt = 0.
- Index: idx = req_pc[INDEX_W+1:2] XOR zero-extended GHR[HIST_W-1:0]; HIST_W=0 → plain bimodal.
- Lookup: on req_valid, next cycle pred_valid=1, pred_index=idx, pred_taken=MSB of counter. No request → pred_valid=0; pred_taken/pred_index hold previous values.
- Update on upd_valid: PHT[upd_index] increments (saturating at 2^CTR_W-1) if upd_taken, else decrements (saturating at 0). GHR ← {GHR[HIST_W-2:0], upd_taken} (non-speculative; HIST_W=1 → GHR=upd_taken).
- Misprediction: upd_valid && upd_taken≠upd_pred → mispredict_cnt+1, saturating at all-ones, never wraps.
- Requests accepted every cycle; no backpressure; updates never stall.

## Timing
- Lookup latency 1 cycle; throughput 1 lookup + 1 update per cycle.
- Same-cycle request and update: idx uses GHR value before this cycle's update. If upd_index == idx, the prediction reflects the post-update counter (write-first bypass). Different index: prediction uses current table contents.
- Update takes effect in PHT and GHR at the same clock edge; next-cycle lookups see both.
- rst_n asserted mid-operation: outputs go to reset values without waiting for clk; an in-flight prediction is dropped. Deassertion is synchronised externally; first request accepted on the first edge with rst_n high.

## Structure
- Package bp_pkg: saturating next-counter function (ctr, taken, CTR_W), WEAK_NT constant computation, index-hash function.
- Sub-module gshare_pht: 2^INDEX_W × CTR_W flop array with async reset, one read port with write-first bypass, one read-modify-write update port. Top holds GHR, output registers and mispredict counter.

## Test plan
- Reset: after rst_n low, request pc=0x40 → pred_valid=1 next cycle, pred_taken=0, pred_index=0x10, mispredict_cnt=0.
- Saturation (CTR_W=2, HIST_W=0): 4× update idx 5 taken → counter 3, request pc=0x14 predicts 1; 1 not-taken → still 1; 2 more not-taken → 0, repeated not-taken holds 0.
- History hash: updates taken,taken (GHR=0b11), request pc=0x40 → pred_index=0x13.
- Bypass: counter idx 3 = 1, same cycle update idx 3 taken and request hashing to 3 → pred_taken=1.
- Mispredict counter (CNT_W=4): 20 updates with upd_taken≠upd_pred → mispredict_cnt=15; matched updates leave it unchanged.
- Async reset mid-stream: assert rst_n between edges while pred_valid=1 → pred_valid, mispredict_cnt, GHR zero immediately; PHT back to WEAK_NT.
